// File: rtl/adder_seq_pkg.sv
// Shared types and width helpers for the sliced-add sequencer.
package adder_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index counter width: ceil(log2(n)), never less than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int wide_width(input int nb, input int ns);
      return nb * ns;
   endfunction

endpackage

// File: rtl/slice_counter.sv
// Slice index counter: synchronous clear, count enable, wraps after the top slice.
module slice_counter
   import adder_seq_pkg::*;
#(
   parameter  int NUM_SLICES = 4,
   localparam int IW         = idx_width(NUM_SLICES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [IW-1:0] idx,
   output logic          last
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

   assign last = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst || clr)
         idx <= '0;
      else if (en)
         idx <= last ? '0 : idx + IW'(1);
   end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Drives a shared narrow adder one slice per cycle (LSB first) to build a wide sum.
// Optional ADDER_SEQ_SUB_EN adds a 'sub' port for A-B via inverted B and carry-in of 1.
module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter  int NUM_BITS   = 4,
   parameter  int NUM_SLICES = 4,
   localparam int W          = wide_width(NUM_BITS, NUM_SLICES),
   localparam int IW         = idx_width(NUM_SLICES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
`ifdef ADDER_SEQ_SUB_EN
   input  logic                sub,
`endif
   input  logic [W-1:0]        op_a,
   input  logic [W-1:0]        op_b,
   input  logic                carry_in,
   output logic                busy,
   output logic                done,
   output logic [W-1:0]        result,
   output logic                overflow,
   output logic [NUM_BITS-1:0] add_a,
   output logic [NUM_BITS-1:0] add_b,
   output logic                add_cin,
   input  logic [NUM_BITS-1:0] add_sum,
   input  logic                add_cout
);

   state_t state, state_nxt;
   logic [NUM_SLICES-1:0][NUM_BITS-1:0] a_q, b_q, res_q;
   logic          carry_q, ovf_q, init_carry;
   logic          cnt_clr, cnt_en, last;
   logic [IW-1:0] idx;
   logic [NUM_BITS-1:0] b_slice;

`ifdef ADDER_SEQ_SUB_EN
   logic sub_q;
   // Two's-complement subtract: A + ~B + 1, so the carry chain starts at 1.
   assign init_carry = sub ? 1'b1 : carry_in;
   assign b_slice    = sub_q ? ~b_q[idx] : b_q[idx];
`else
   assign init_carry = carry_in;
   assign b_slice    = b_q[idx];
`endif

   slice_counter #(.NUM_SLICES(NUM_SLICES)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .idx  (idx),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nxt = RUN;
            cnt_clr   = 1'b1;
         end
         RUN: begin
            cnt_en = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               a_q     <= op_a;
               b_q     <= op_b;
               carry_q <= init_carry;
               res_q   <= '0;
`ifdef ADDER_SEQ_SUB_EN
               sub_q   <= sub;
`endif
            end
            RUN: begin
               res_q[idx] <= add_sum;
               carry_q    <= add_cout;
               if (last) ovf_q <= add_cout;
            end
            default: ;
         endcase
      end
   end

   // Adder inputs are only live while slicing; quiet otherwise.
   assign add_a    = (state == RUN) ? a_q[idx] : '0;
   assign add_b    = (state == RUN) ? b_slice  : '0;
   assign add_cin  = (state == RUN) & carry_q;

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign result   = res_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a behavioural 4-bit adder attached.
module tb_adder_seq_ctrl;

   localparam int NB = 4;
   localparam int NS = 4;
   localparam int W  = NB * NS;

   logic          clk = 1'b0;
   logic          rst, start, carry_in;
   logic [W-1:0]  op_a, op_b, result;
   logic          busy, done, overflow, add_cin, add_cout;
   logic [NB-1:0] add_a, add_b, add_sum;
`ifdef ADDER_SEQ_SUB_EN
   logic          sub = 1'b0;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   // Stand-in for the shared adder_nbit.
   assign {add_cout, add_sum} = add_a + add_b + add_cin;

   adder_seq_ctrl #(.NUM_BITS(NB), .NUM_SLICES(NS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
`ifdef ADDER_SEQ_SUB_EN
      .sub      (sub),
`endif
      .op_a     (op_a),
      .op_b     (op_b),
      .carry_in (carry_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_res;
      logic         exp_ovf;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns one negedge after the start edge.
   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      op_a = a; op_b = b; carry_in = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts clock edges since the start edge (inclusive) until done is seen.
   task automatic wait_done(input int from, output int edges);
      edges = from;
      while (!done && edges < 20) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
   endtask

   vec_t vecs[7];
   int   edges, pulses;

   initial begin
      vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
      vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
      vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("reset busy",     32'(busy),     32'd0);
      chk("reset done",     32'(done),     32'd0);
      chk("reset result",   32'(result),   32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset add_a",    32'(add_a),    32'd0);
      chk("reset add_cin",  32'(add_cin),  32'd0);
      rst = 1'b0;

      // Back-to-back: each new start lands in the first IDLE cycle after DONE.
      for (int i = 0; i < 7; i++) begin
         do_start(vecs[i].a, vecs[i].b, vecs[i].cin);
         chk($sformatf("v%0d busy", i),     32'(busy),    32'd1);
         chk($sformatf("v%0d add_a0", i),   32'(add_a),   32'(vecs[i].a[3:0]));
         chk($sformatf("v%0d add_b0", i),   32'(add_b),   32'(vecs[i].b[3:0]));
         chk($sformatf("v%0d add_cin0", i), 32'(add_cin), 32'(vecs[i].cin));
         wait_done(1, edges);
         chk($sformatf("v%0d latency", i),  32'(edges),    32'(NS + 1));
         chk($sformatf("v%0d result", i),   32'(result),   32'(vecs[i].exp_res));
         chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
         @(negedge clk);
         chk($sformatf("v%0d done drop", i), 32'(done), 32'd0);
         chk($sformatf("v%0d busy drop", i), 32'(busy), 32'd0);
         chk($sformatf("v%0d hold", i),      32'(result), 32'(vecs[i].exp_res));
      end

      // Start and operand changes while busy must be ignored.
      do_start(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      op_a = 16'hFFFF; op_b = 16'hFFFF; carry_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, edges);
      chk("busy-start latency", 32'(edges),    32'(NS + 1));
      chk("busy-start result",  32'(result),   32'h3333);
      chk("busy-start ovf",     32'(overflow), 32'd0);
      @(negedge clk);
      chk("busy-start busy drop", 32'(busy), 32'd0);
      count_done(8, pulses);
      chk("busy-start extra done", 32'(pulses), 32'd0);

      // Reset in the second RUN cycle: full clear, no done pulse.
      do_start(16'hFFFF, 16'h0001, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy",   32'(busy),     32'd0);
      chk("midrst done",   32'(done),     32'd0);
      chk("midrst result", 32'(result),   32'd0);
      chk("midrst ovf",    32'(overflow), 32'd0);
      count_done(8, pulses);
      chk("midrst no done", 32'(pulses), 32'd0);

      do_start(16'h0F0F, 16'h0101, 1'b0);
      wait_done(1, edges);
      chk("post-rst latency", 32'(edges),    32'(NS + 1));
      chk("post-rst result",  32'(result),   32'h1010);
      chk("post-rst ovf",     32'(overflow), 32'd0);
      @(negedge clk);

      // Reset wins over a simultaneous start.
      op_a = 16'h0001; op_b = 16'h0001; carry_in = 1'b0;
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst+start busy",   32'(busy),   32'd0);
      chk("rst+start result", 32'(result), 32'd0);
      count_done(8, pulses);
      chk("rst+start no done", 32'(pulses), 32'd0);

`ifdef ADDER_SEQ_SUB_EN
      sub = 1'b1;
      do_start(16'h0005, 16'h0007, 1'b0);
      chk("sub add_b0",  32'(add_b),   32'h8);
      chk("sub add_cin", 32'(add_cin), 32'd1);
      wait_done(1, edges);
      chk("sub 5-7 result", 32'(result),   32'hFFFE);
      chk("sub 5-7 ovf",    32'(overflow), 32'd0);
      @(negedge clk);
      do_start(16'h0007, 16'h0005, 1'b0);
      wait_done(1, edges);
      chk("sub 7-5 result", 32'(result),   32'h0002);
      chk("sub 7-5 ovf",    32'(overflow), 32'd1);
      @(negedge clk);
      sub = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
